// File: rtl/load_extend_ctrl.sv
// Sub-word load sequencer: alignment check, word-aligned req/ack fetch, lane select and extension.
// Optional macro LOAD_TIMEOUT_EN adds a bounded wait for mem_ack.
module load_extend_ctrl #(
  parameter int BIG_ENDIAN     = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t     state;
  logic [2:0] op_q;
  logic [1:0] off_q;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

`ifdef LOAD_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
`endif

  function automatic logic cmd_fault(input logic [2:0] o, input logic [1:0] a);
    case (o)
      3'b000, 3'b100: cmd_fault = 1'b0;
      3'b001, 3'b101: cmd_fault = a[0];
      3'b011:         cmd_fault = (a != 2'b00);
      default:        cmd_fault = 1'b1;
    endcase
  endfunction

  // lane counts bytes from bit 0; big-endian offsets map to the mirrored lane
  function automatic logic [31:0] extend(input logic [2:0] o, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [1:0]  lane;
    logic [7:0]  b;
    logic [15:0] h;
    lane = (BIG_ENDIAN != 0) ? ~off : off;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (o)
      3'b000:  extend = {{24{b[7]}}, b};
      3'b001:  extend = {{16{h[15]}}, h};
      3'b100:  extend = {24'd0, b};
      3'b101:  extend = {16'd0, h};
      default: extend = w;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= 3'd0;
      off_q    <= 2'd0;
      mem_req  <= 1'b0;
      mem_addr <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= 32'd0;
      err      <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      wait_cnt <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (cmd_fault(op, addr[1:0])) begin
              done   <= 1'b1;
              err    <= 1'b1;
              result <= 32'd0;
              state  <= DONE;
            end else begin
              op_q     <= op;
              off_q    <= addr[1:0];
              mem_addr <= {addr[31:2], 2'b00};
              mem_req  <= 1'b1;
              state    <= REQ;
`ifdef LOAD_TIMEOUT_EN
              wait_cnt <= 16'd0;
`endif
            end
          end
        end
        REQ: begin
          // ack beats a timeout landing on the same cycle
          if (mem_ack) begin
            result  <= extend(op_q, off_q, mem_rdata);
            mem_req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b0;
            state   <= DONE;
          end
`ifdef LOAD_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            result  <= 32'd0;
            mem_req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_extend_ctrl.md
Name: load_extend_ctrl

Overview:
Sequences sub-word loads (LB/LH/LW/LBU/LHU) between the MEM stage and the data memory port. It accepts a load command, checks alignment, issues a word-aligned memory request with a req/ack handshake, selects the addressed byte lane, and sign- or zero-extends the field to 32 bits. It returns a registered result with a one-cycle done pulse. It sits between the MEM-stage control and the data memory, and raises busy so the hazard unit can stall the pipeline.

Parameters:
BIG_ENDIAN, 1, byte-lane order: 1 = byte offset 0 is mem_rdata[31:24]; 0 = byte offset 0 is mem_rdata[7:0]
TIMEOUT_CYCLES, 255, maximum wait for mem_ack (used only with the optional feature); range 1..65535

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  load command strobe; sampled only in IDLE
op  input  3  opcode[2:0]: 000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU; all other codes invalid
addr  input  32  effective byte address
mem_req  output  1  memory read request
mem_addr  output  32  word address, {addr[31:2],2'b00}
mem_ack  input  1  memory read data valid this cycle
mem_rdata  input  32  memory read word
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
result  output  32  extended load value, valid while done=1 and held until the next done
err  output  1  set together with done when the command faulted (misaligned, invalid op or timeout)

Behaviour:
- Reset: asynchronous. On reset, go to IDLE and clear mem_req, mem_addr, busy, done, result and err to 0.
- States: IDLE, REQ, DONE.
- IDLE, start=0: stay in IDLE.
- IDLE, start=1 with a valid, aligned command:
  - Latch op and addr[1:0].
  - Drive mem_addr = {addr[31:2],2'b00}.
  - Next state REQ.
- IDLE, start=1 with a fault:
  - Faults: invalid op; LH/LHU with addr[0]=1; LW with addr[1:0]!=0.
  - Next state DONE with err=1 and result=0. mem_req is never asserted.
- REQ:
  - mem_req=1. mem_addr is stable until ack.
  - When mem_ack=1, capture and extend mem_rdata, then go to DONE.
  - mem_req deasserts on the cycle after ack.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - err holds its value while done=1 and clears to 0 in IDLE.
  - result holds after done deasserts.
- Lane select (BIG_ENDIAN=1):
  - Byte offset n uses mem_rdata[31-8n -: 8].
  - Halfword offset 0 uses [31:16]; offset 2 uses [15:0].
- Lane select (BIG_ENDIAN=0):
  - Byte offset n uses mem_rdata[8n+7 -: 8].
  - Halfword offset 0 uses [15:0]; offset 2 uses [31:16].
- Extension:
  - LB/LH replicate the field MSB into bits [31:N], N = 8 or 16.
  - LBU/LHU zero-fill bits [31:N].
  - LW passes the word through.
- Latency: start at cycle 0 → mem_req at cycle 1. Ack at cycle k (k≥1) → done and result at cycle k+1. Minimum latency is 2 cycles. A fault gives done at cycle 1.
- Handshake edge cases:
  - start while busy=1: ignored; no queuing.
  - mem_ack while not in REQ: ignored.
  - mem_rdata is sampled only on ack.
- Reset mid-operation: mem_req drops asynchronously and no done is produced. The memory side must tolerate an abandoned request.
- busy equals (state != IDLE) and is registered. There is no combinational path from start to any output.

Optional Feature:
LOAD_TIMEOUT_EN:
- Defined:
  - A 16-bit wait counter clears on entry to REQ and increments each cycle in REQ without ack.
  - When it reaches TIMEOUT_CYCLES, drop mem_req and go to DONE with err=1 and result=0.
  - An ack in the same cycle the count reaches TIMEOUT_CYCLES wins: normal completion, err=0.
- Undefined: no counter is built, and REQ waits indefinitely for mem_ack.

Test Plan:
1. LB at addr 0x1003, BIG_ENDIAN=1, mem_rdata=0x123456F0, ack at cycle 3 → mem_addr=0x1000; done at cycle 4; result=0xFFFFFFF0; err=0.
2. LHU at addr 0x2002, mem_rdata=0xAAAA8001 → result=0x00008001. The same command with LH → result=0xFFFF8001.
3. LW at addr 0x3001 → done at cycle 1; err=1; result=0; mem_req never asserted. The same applies to LH at 0x3001 and op=010.
4. start pulsed again at cycles 1–3 during a pending LW at 0x4000 with ack at cycle 5 → only one request is made; a single done at cycle 6; result=mem_rdata.
5. Reset asserted at cycle 2 while mem_req=1 → mem_req, busy, done and result are 0 immediately; no done after reset release; a new LW then completes normally.
6. With LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → mem_req falls after 4 REQ cycles; done=1 with err=1. With ack on the 4th cycle → err=0 and valid data.
